// File: rtl/rf_ctl.sv
// Command sequencer for the A/B/C/D/F register file: expands one accepted
// command into registered one-hot load/output strobes and the write data bus.
module rf_ctl #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [7:0]       i_cmd_op,
  input  logic [W-1:0]     i_cmd_imm,
  output logic [W-1:0]     o_rf_d,
  input  logic [W-1:0]     i_rf_p,
  output logic [4:0]       o_rf_in,
  output logic [4:0]       o_rf_out,
  output logic             o_rf_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StClr, StDone, StErr} state_e;

  localparam logic [1:0] ClsNop = 2'b00;
  localparam logic [1:0] ClsMov = 2'b01;
  localparam logic [1:0] ClsLdi = 2'b10;

  state_e           r_state, w_state_nxt;
  logic [2:0]       r_dst, w_dst_nxt;
  logic [2:0]       r_src, w_src_nxt;
  logic [W-1:0]     r_tmp, w_tmp_nxt;
  logic [W-1:0]     r_rf_d;
  logic [4:0]       r_rf_in, r_rf_out;
  logic             r_rf_rst, r_done, r_err;
  logic [CNT_W-1:0] r_retired;

  logic       w_accept;
  logic [1:0] w_cls;
  logic [2:0] w_op_dst, w_op_src;
  logic       w_dst_bad, w_src_bad;

  assign w_accept  = i_cmd_valid && (r_state == StIdle);
  assign w_cls     = i_cmd_op[7:6];
  assign w_op_dst  = i_cmd_op[5:3];
  assign w_op_src  = i_cmd_op[2:0];
  assign w_dst_bad = (w_op_dst > 3'd4);
  assign w_src_bad = (w_op_src > 3'd4);

  always_comb begin
    w_state_nxt = r_state;
    w_dst_nxt   = r_dst;
    w_src_nxt   = r_src;
    w_tmp_nxt   = r_tmp;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_dst_nxt = w_op_dst;
          w_src_nxt = w_op_src;
          if (w_cls == ClsNop) begin
            w_state_nxt = StDone;
          end else if (w_cls == ClsMov) begin
            w_state_nxt = (w_dst_bad || w_src_bad) ? StErr : StRead;
          end else if (w_cls == ClsLdi) begin
            w_state_nxt = w_dst_bad ? StErr : StWrite;
            w_tmp_nxt   = i_cmd_imm;
          end else begin
            w_state_nxt = StClr;
          end
        end
      end
      StRead: begin
        w_tmp_nxt   = i_rf_p;
        w_state_nxt = StWrite;
      end
      StWrite, StClr: w_state_nxt = StDone;
      StDone, StErr:  w_state_nxt = StIdle;
      default:        w_state_nxt = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_dst     <= '0;
      r_src     <= '0;
      r_tmp     <= '0;
      r_rf_d    <= '0;
      r_rf_in   <= '0;
      r_rf_out  <= '0;
      r_rf_rst  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dst    <= w_dst_nxt;
      r_src    <= w_src_nxt;
      r_tmp    <= w_tmp_nxt;
      r_rf_d   <= (w_state_nxt == StWrite) ? w_tmp_nxt : '0;
      r_rf_in  <= (w_state_nxt == StWrite) ? (5'b00001 << w_dst_nxt) : 5'b00000;
      r_rf_out <= (w_state_nxt == StRead) ? (5'b00001 << w_src_nxt) : 5'b00000;
      r_rf_rst <= (w_state_nxt == StClr);
      r_done   <= (w_state_nxt == StDone);
      r_err    <= (w_state_nxt == StErr);
      if (w_state_nxt == StDone) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign o_cmd_ready = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_rf_d      = r_rf_d;
  assign o_rf_in     = r_rf_in;
  assign o_rf_out    = r_rf_out;
  assign o_rf_rst    = r_rf_rst;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_rf_ctl.sv
// Bench for rf_ctl: directed and random commands checked cycle by cycle against
// a T-state table model; a CNT_W=4 twin shares the stimulus to exercise counter wrap.
module tb_rf_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] op = 8'h00;
  logic [7:0] imm = 8'h00;
  logic [7:0] rf_p = 8'h00;

  logic        ready, rf_rst, busy, done, err;
  logic [7:0]  rf_d;
  logic [4:0]  rf_in, rf_out;
  logic [15:0] retired;

  logic       ready4, rf_rst4, busy4, done4, err4;
  logic [7:0] rf_d4;
  logic [4:0] rf_in4, rf_out4;
  logic [3:0] retired4;

  int checks = 0;
  int errors = 0;
  int m_ret  = 0;

  always #5 clk = ~clk;

  rf_ctl #(.W(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready), .i_cmd_op(op),
    .i_cmd_imm(imm), .o_rf_d(rf_d), .i_rf_p(rf_p), .o_rf_in(rf_in), .o_rf_out(rf_out),
    .o_rf_rst(rf_rst), .o_busy(busy), .o_done(done), .o_err(err), .o_retired(retired)
  );

  rf_ctl #(.W(8), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready4), .i_cmd_op(op),
    .i_cmd_imm(imm), .o_rf_d(rf_d4), .i_rf_p(rf_p), .o_rf_in(rf_in4), .o_rf_out(rf_out4),
    .o_rf_rst(rf_rst4), .o_busy(busy4), .o_done(done4), .o_err(err4), .o_retired(retired4)
  );

  // Strobe invariants, every cycle.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(rf_in) && $onehot0(rf_out) && !((|rf_in) && (|rf_out))
            && ((|rf_in) || rf_d == 8'h00))
    else begin
      errors++;
      $error("FAIL invariant observed rf_in=%b rf_out=%b rf_d=%h", rf_in, rf_out, rf_d);
    end
  end

  function automatic logic [22:0] pack(logic [4:0] i_in, logic [4:0] i_out, logic [7:0] d,
                                       logic r, logic dn, logic er, logic rdy, logic bsy);
    return {i_in, i_out, d, r, dn, er, rdy, bsy};
  endfunction

  function automatic bit is_bad(logic [7:0] o);
    logic [2:0] dc, sc;
    dc = o[5:3];
    sc = o[2:0];
    return (o[7:6] == 2'b01 && (dc > 3'd4 || sc > 3'd4)) || (o[7:6] == 2'b10 && dc > 3'd4);
  endfunction

  function automatic int cmd_len(logic [7:0] o);
    if (is_bad(o) || o[7:6] == 2'b00) return 1;
    if (o[7:6] == 2'b01) return 3;
    return 2;
  endfunction

  // Expected outputs in T-state k (k=1 is the cycle after the accept edge).
  function automatic logic [22:0] exp_step(logic [7:0] o, logic [7:0] im, logic [7:0] p, int k);
    logic [4:0] dst_oh, src_oh;
    int n;
    dst_oh = 5'b00001 << o[5:3];
    src_oh = 5'b00001 << o[2:0];
    n = cmd_len(o);
    if (is_bad(o)) return pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    if (k == n) return pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    case (o[7:6])
      2'b01: begin
        if (k == 1) return pack(5'b0, src_oh, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        return pack(dst_oh, 5'b0, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      2'b10:   return pack(dst_oh, 5'b0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      default: return pack(5'b0, 5'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endcase
  endfunction

  task automatic check_cycle(input string tag, input logic [22:0] e);
    logic [38:0] obs, ex;
    logic [15:0] r16;
    logic [3:0]  r4;
    r16 = m_ret[15:0];
    r4  = m_ret[3:0];
    obs = {rf_in, rf_out, rf_d, rf_rst, done, err, ready, busy, retired};
    ex  = {e, r16};
    checks++;
    assert (obs === ex)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
    checks++;
    assert (retired4 === r4)
    else begin
      errors++;
      $error("FAIL %s_ret4 observed=%h expected=%h", tag, retired4, r4);
    end
  endtask

  // Moves into the next (idle) cycle, accepts one command, checks every T-state.
  // Inputs carry random junk while busy; the controller must ignore them.
  task automatic cmd(input string tag, input logic [7:0] o, input logic [7:0] im,
                     input logic [7:0] p);
    logic [22:0] e;
    @(posedge clk); #1;
    check_cycle({tag, "_idle"}, pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    valid = 1'b1;
    op    = o;
    imm   = im;
    rf_p  = 8'($urandom);
    for (int k = 1; k <= cmd_len(o); k++) begin
      @(posedge clk); #1;
      valid = 1'($urandom);
      op    = 8'($urandom);
      imm   = 8'($urandom);
      rf_p  = (k == 1) ? p : 8'($urandom);
      e = exp_step(o, im, p, k);
      if (e[3]) m_ret++;
      check_cycle($sformatf("%s_t%0d", tag, k), e);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    rst = 1'b0;

    cmd("ldi_a", 8'h80, 8'd100, 8'h00);
    cmd("mov_b_a", 8'h48, 8'h00, 8'd100);
    cmd("ldi_dst5", 8'hA8, 8'h11, 8'h00);
    cmd("mov_src7", 8'h47, 8'h22, 8'h33);
    cmd("clr", 8'hC0, 8'h44, 8'h55);
    cmd("clr_junk", 8'hFF, 8'h00, 8'h00);
    cmd("nop_junk", 8'h3F, 8'hAA, 8'h00);
    cmd("ldi_c_src7", 8'h97, 8'h5A, 8'h00);
    cmd("mov_d_d", 8'h5B, 8'h00, 8'hC3);
    cmd("mov_f_d", 8'h63, 8'h00, 8'h0F);
    cmd("ldi_f", 8'hA0, 8'hFF, 8'h00);

    // Idle cycle with valid low: nothing may be accepted.
    @(posedge clk); #1;
    valid = 1'b0;
    check_cycle("gap", pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Reset while a MOV sits in READ.
    @(posedge clk); #1;
    check_cycle("abort_idle", pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    valid = 1'b1;
    op    = 8'h48;
    @(posedge clk); #1;
    valid = 1'($urandom);
    check_cycle("abort_read", exp_step(8'h48, 8'h00, 8'h00, 1));
    rst = 1'b1;
    @(posedge clk); #1;
    m_ret = 0;
    check_cycle("abort", pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    rst   = 1'b0;
    valid = 1'b0;

    // 17 NOPs: the 4-bit twin wraps 15 -> 0 -> 1.
    for (int i = 0; i < 17; i++) cmd("nop_wrap", 8'h00, 8'($urandom), 8'($urandom));

    for (int i = 0; i < 120; i++) cmd("rand", 8'($urandom), 8'($urandom), 8'($urandom));

    @(posedge clk); #1;
    valid = 1'b0;
    check_cycle("final", pack(5'b0, 5'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
